pipelined_bypass_adder: RTL and testbench

Parametrised, pipelined carry-bypass adder/subtractor with a valid/ready handshake on both sides. The operand width is split into bypass blocks of `BLOCK` bits, and `BPS` blocks are grouped into each pipeline stage. The carry is registered between stages, and operand slices are skewed so that one new operation can be accepted every cycle. It is the successor to the combinational 32-bit bypass adder: it adds width/block/pipeline generality, a subtract mode, backpressure, and the same signed-overflow flags.

---
 rtl/pipelined_bypass_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_bypass_adder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor: one slice of BLOCK*BPS bits per stage,
// the carry registered between stages, and a valid/ready handshake with bubble collapse.
module pipelined_bypass_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             pos_overflow,
  output logic             neg_overflow
);

  localparam int SW = BLOCK * BPS;
  localparam int L  = WIDTH / SW;

  logic [WIDTH-1:0] aQ   [L];
  logic [WIDTH-1:0] beQ  [L];
  logic [WIDTH-1:0] sumQ [L];
  logic             carryQ [L];
  logic [L-1:0]     validQ;

  logic [WIDTH-1:0] aD   [L];
  logic [WIDTH-1:0] beD  [L];
  logic [WIDTH-1:0] sumD [L];
  logic             carryD [L];
  logic [L-1:0]     validD;

  logic [L-1:0]     adv;
  logic [L-1:0]     load;
  logic [WIDTH-1:0] beIn;
  logic             c0;

  // One pipeline slice: BPS ripple blocks, each skipping its carry-in straight
  // through when every bit of the block propagates.
  function automatic logic [SW:0] stageAdd(input logic [SW-1:0] x,
                                           input logic [SW-1:0] y,
                                           input logic          ci);
    logic [SW-1:0] sum;
    logic          c;
    logic          bc;
    logic          p;
    int            idx;
    sum = '0;
    c   = ci;
    for (int blk = 0; blk < BPS; blk++) begin
      bc = c;
      p  = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        idx      = blk * BLOCK + i;
        sum[idx] = x[idx] ^ y[idx] ^ bc;
        bc       = (x[idx] & y[idx]) | ((x[idx] ^ y[idx]) & bc);
        p        = p & (x[idx] ^ y[idx]);
      end
      c = p ? c : bc;
    end
    return {c, sum};
  endfunction

  assign beIn = sub ? ~b : b;
  assign c0   = sub | cin;

  // A stage is blocked only when it and every stage after it are full and the
  // consumer is not taking the result.
  always_comb begin
    logic blocked;
    blocked = ~out_ready;
    adv     = '0;
    for (int k = L - 1; k >= 0; k--) begin
      adv[k]  = validQ[k] & ~blocked;
      blocked = blocked & validQ[k];
    end
    in_ready = ~validQ[0] | adv[0];
    load     = '0;
    load[0]  = in_valid & in_ready;
    for (int k = 1; k < L; k++) begin
      load[k] = adv[k-1];
    end
    for (int k = 0; k < L; k++) begin
      validD[k] = load[k] | (validQ[k] & ~adv[k]);
    end
  end

  always_comb begin
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcBe;
    logic [WIDTH-1:0] srcSum;
    logic             srcC;
    logic [SW:0]      res;
    for (int k = 0; k < L; k++) begin
      if (k == 0) begin
        srcA   = a;
        srcBe  = beIn;
        srcSum = '0;
        srcC   = c0;
      end else begin
        srcA   = aQ[k-1];
        srcBe  = beQ[k-1];
        srcSum = sumQ[k-1];
        srcC   = carryQ[k-1];
      end
      res                  = stageAdd(srcA[k*SW +: SW], srcBe[k*SW +: SW], srcC);
      aD[k]                = srcA;
      beD[k]               = srcBe;
      sumD[k]              = srcSum;
      sumD[k][k*SW +: SW]  = res[SW-1:0];
      carryD[k]            = res[SW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validQ <= '0;
      for (int k = 0; k < L; k++) begin
        aQ[k]     <= '0;
        beQ[k]    <= '0;
        sumQ[k]   <= '0;
        carryQ[k] <= 1'b0;
      end
    end else begin
      validQ <= validD;
      for (int k = 0; k < L; k++) begin
        if (load[k]) begin
          aQ[k]     <= aD[k];
          beQ[k]    <= beD[k];
          sumQ[k]   <= sumD[k];
          carryQ[k] <= carryD[k];
        end
      end
    end
  end

  assign out_valid    = validQ[L-1];
  assign s            = sumQ[L-1];
  assign cout         = carryQ[L-1];
  assign pos_overflow = ~aQ[L-1][WIDTH-1] & ~beQ[L-1][WIDTH-1] &  sumQ[L-1][WIDTH-1];
  assign neg_overflow =  aQ[L-1][WIDTH-1] &  beQ[L-1][WIDTH-1] & ~sumQ[L-1][WIDTH-1];

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Self-checking bench for pipelined_bypass_adder: directed corner cases, backpressure,
// mid-flight reset and a randomized stream against a queue-based arithmetic model.
module tb_pipelined_bypass_adder;

  localparam int WIDTH = 32;
  localparam int BLOCK = 4;
  localparam int BPS   = 2;
  localparam int L     = WIDTH / (BLOCK * BPS);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             pos_overflow;
  logic             neg_overflow;

  always #5 clk = ~clk;

  pipelined_bypass_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK), .BPS(BPS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
    .pos_overflow(pos_overflow), .neg_overflow(neg_overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             pos;
    logic             neg;
    int               acc;
  } exp_t;

  exp_t             q[$];
  int               edgeCount    = 0;
  int               lastDepart   = 0;
  int               compareCount = 0;
  int               failCount    = 0;
  logic             lastAccepted;
  logic [WIDTH-1:0] lastS;
  logic             lastCout;
  logic             lastPos;
  logic             lastNeg;
  int               lastAcc;
  int               lastEmitEdge;

  // Reference: a (WIDTH+1)-bit sum of A, the effective B and the effective carry.
  function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic icin, input logic isub, input int acc);
    exp_t           e;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    be     = isub ? ~ib : ib;
    full   = {1'b0, ia} + {1'b0, be} + {{WIDTH{1'b0}}, (isub ? 1'b1 : icin)};
    e.s    = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.pos  = !ia[WIDTH-1] && !be[WIDTH-1] &&  e.s[WIDTH-1];
    e.neg  =  ia[WIDTH-1] &&  be[WIDTH-1] && !e.s[WIDTH-1];
    e.acc  = acc;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compareCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample after settling, and
  // account for accept/emit as the next rising edge will see them.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] ia,
                               input logic [WIDTH-1:0] ib, input logic icin,
                               input logic isub, input logic ordy);
    logic expVis;
    int   due;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = ordy;
    #1;
    checkOutput("in_ready", 64'(in_ready), 64'(!(q.size() == L && !ordy)));
    expVis = 1'b0;
    if (q.size() > 0) begin
      due    = (q[0].acc + L - 1 > lastDepart) ? q[0].acc + L - 1 : lastDepart;
      expVis = (edgeCount >= due);
    end
    checkOutput("out_valid", 64'(out_valid), 64'(expVis));
    if (out_valid && q.size() > 0) begin
      checkOutput("s",            64'(s),            64'(q[0].s));
      checkOutput("cout",         64'(cout),         64'(q[0].cout));
      checkOutput("pos_overflow", 64'(pos_overflow), 64'(q[0].pos));
      checkOutput("neg_overflow", 64'(neg_overflow), 64'(q[0].neg));
      if (ordy) begin
        lastS        = s;
        lastCout     = cout;
        lastPos      = pos_overflow;
        lastNeg      = neg_overflow;
        lastAcc      = q[0].acc;
        lastEmitEdge = edgeCount;
        lastDepart   = edgeCount + 1;
        void'(q.pop_front());
      end
    end
    lastAccepted = iv && in_ready;
    if (lastAccepted) q.push_back(model(ia, ib, icin, isub, edgeCount + 1));
    @(posedge clk);
    edgeCount++;
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      edgeCount++;
    end
    q.delete();
    lastDepart = 0;
    @(negedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid),    64'(0));
    checkOutput("rst_s",         64'(s),            64'(0));
    checkOutput("rst_cout",      64'(cout),         64'(0));
    checkOutput("rst_pos",       64'(pos_overflow), 64'(0));
    checkOutput("rst_neg",       64'(neg_overflow), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int left;
    left = budget;
    while (q.size() > 0 && left > 0) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      left--;
    end
    checkOutput("drain_timeout", 64'(q.size()), 64'(0));
  endtask

  task automatic directedOp(input string tag, input logic [WIDTH-1:0] ia,
                            input logic [WIDTH-1:0] ib, input logic icin, input logic isub,
                            input logic [WIDTH-1:0] es, input logic ec,
                            input logic ep, input logic en);
    applyStimulus(1'b1, ia, ib, icin, isub, 1'b1);
    checkOutput({tag, "_accepted"}, 64'(lastAccepted), 64'(1));
    drain(20);
    checkOutput({tag, "_s"},       64'(lastS),    64'(es));
    checkOutput({tag, "_cout"},    64'(lastCout), 64'(ec));
    checkOutput({tag, "_pos"},     64'(lastPos),  64'(ep));
    checkOutput({tag, "_neg"},     64'(lastNeg),  64'(en));
    checkOutput({tag, "_latency"}, 64'(lastEmitEdge - lastAcc), 64'(L - 1));
  endtask

  initial begin
    int   sent;
    logic sawFull;
    logic ordy;

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    applyReset(2);

    // Carry propagation across every bypass block, and a single-block carry.
    directedOp("full_prop", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    directedOp("low_prop",  32'h0000_000F, 32'h0, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0);

    // Signed overflow in both directions.
    directedOp("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directedOp("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Subtract forces the carry-in to 1 regardless of cin.
    directedOp("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    directedOp("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Backpressure: consumer stalls for cycles 3..8 of an 8-op stream.
    sent    = 0;
    sawFull = 1'b0;
    for (int cyc = 0; cyc < 60 && (sent < 8 || q.size() > 0); cyc++) begin
      ordy = !(cyc >= 3 && cyc <= 8);
      applyStimulus(sent < 8, 32'(sent), 32'(sent << 8), 1'b0, 1'b0, ordy);
      if (lastAccepted) sent++;
      if (!in_ready && sent < 8) sawFull = 1'b1;
    end
    checkOutput("bp_sent",     64'(sent),    64'(8));
    checkOutput("bp_full",     64'(sawFull), 64'(1));
    checkOutput("bp_last_s",   64'(lastS),   64'(32'h0000_0707));
    checkOutput("bp_drained",  64'(q.size()), 64'(0));

    // Reset with three operations in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i + 100), 32'(i), 1'b0, 1'b0, 1'b0);
    applyReset(1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    directedOp("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    // Randomized stream with random gaps and random consumer stalls.
    sent = 0;
    for (int cyc = 0; cyc < 6000 && sent < 1000; cyc++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h0000_0000;
      applyStimulus($urandom_range(0, 7) != 0, ra, rb, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      if (lastAccepted) sent++;
    end
    drain(40);
    checkOutput("rand_sent", 64'(sent), 64'(1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
